dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: the processor memory stage (cpu) and a secondary master (dma: loader/debug/VGA).

---
 rtl/dmem_arbiter.sv | 126 ++++++++++++
 tb/tb_dmem_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the cpu memory stage and a
//   secondary dma master (loader/debug/VGA). The cpu has fixed priority. A
//   starvation counter forces one dma slot after STARVE_LIMIT consecutive
//   contended cpu wins. Read data returns one cycle after the grant, and is
//   qualified by a registered per-owner valid.
//
//   Optional feature: define DMEM_ARB_PERF_EN to build the contention
//   performance counters. Without it, conflict_count and dma_win_count
//   read as zero.
//
// Ports
//   clock, reset        master clock; asynchronous active-high reset
//   cpu_*               cpu request/write-enable/address/write-data in;
//                       gnt/stall/rvalid out
//   dma_*               dma request/write-enable/address/write-data in;
//                       gnt/rvalid out
//   rdata               shared read data (equal to mem_q); qualify with *_rvalid
//   mem_*               dmem address/data/write-enable out, mem_q in
//   conflict_count      contended cycles (perf build only)
//   dma_win_count       dma grants during contention (perf build only)
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_wren,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  input  logic                  dma_req,
  input  logic                  dma_wren,
  input  logic [ADDR_WIDTH-1:0] dma_addr,
  input  logic [DATA_WIDTH-1:0] dma_wdata,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [31:0]           conflict_count,
  output logic [31:0]           dma_win_count
);

  logic [7:0] starveCnt;
  logic       cpuRdQ;
  logic       dmaRdQ;
  logic       forceDma;

  // A zero limit makes dma win every contended cycle. Handle it separately
  // so the counter compare never degenerates into an always-true test.
  generate
    if (STARVE_LIMIT == 0) begin : gForceAlways
      assign forceDma = dma_req;
    end else begin : gForceCnt
      assign forceDma = dma_req & (starveCnt >= 8'(STARVE_LIMIT));
    end
  endgenerate

  assign cpu_gnt    = cpu_req & ~forceDma;
  assign dma_gnt    = dma_req & ~cpu_gnt;
  assign cpu_stall  = cpu_req & ~cpu_gnt;
  assign cpu_rvalid = cpuRdQ;
  assign dma_rvalid = dmaRdQ;
  assign rdata      = mem_q;

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (cpu_gnt) begin
      mem_address = cpu_addr;
      mem_data    = cpu_wdata;
      mem_wren    = cpu_wren;
    end else if (dma_gnt) begin
      mem_address = dma_addr;
      mem_data    = dma_wdata;
      mem_wren    = dma_wren;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starveCnt <= '0;
      cpuRdQ    <= 1'b0;
      dmaRdQ    <= 1'b0;
    end else begin
      // The count only survives while dma keeps asking and keeps losing.
      if (!dma_req || dma_gnt) begin
        starveCnt <= '0;
      end else if (cpu_req && cpu_gnt && starveCnt != 8'hFF) begin
        starveCnt <= starveCnt + 8'd1;
      end
      cpuRdQ <= cpu_gnt & ~cpu_wren;
      dmaRdQ <= dma_gnt & ~dma_wren;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [31:0] conflictCnt;
  logic [31:0] dmaWinCnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflictCnt <= '0;
      dmaWinCnt   <= '0;
    end else if (cpu_req && dma_req) begin
      conflictCnt <= conflictCnt + 32'd1;
      if (dma_gnt) dmaWinCnt <= dmaWinCnt + 32'd1;
    end
  end

  assign conflict_count = conflictCnt;
  assign dma_win_count  = dmaWinCnt;
`else
  assign conflict_count = '0;
  assign dma_win_count  = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter: directed scenarios followed by
//   randomized traffic, scored against a transaction-level reference model.
//   A second instance, built with a zero starvation limit, covers the
//   dma-always-wins case.
module tb_dmem_arbiter;
  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          cpuReq, cpuWren, dmaReq, dmaWren;
  logic [AW-1:0] cpuAddr, dmaAddr;
  logic [DW-1:0] cpuWdata, dmaWdata;
  logic          cpuGnt, cpuStall, cpuRvalid, dmaGnt, dmaRvalid, memWren;
  logic [DW-1:0] rdata, memData, memQ;
  logic [AW-1:0] memAddress;
  logic [31:0]   conflictCount, dmaWinCount;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clk), .reset(rst),
    .cpu_req(cpuReq), .cpu_wren(cpuWren), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_gnt(cpuGnt), .cpu_stall(cpuStall), .cpu_rvalid(cpuRvalid),
    .dma_req(dmaReq), .dma_wren(dmaWren), .dma_addr(dmaAddr), .dma_wdata(dmaWdata),
    .dma_gnt(dmaGnt), .dma_rvalid(dmaRvalid), .rdata(rdata),
    .mem_address(memAddress), .mem_data(memData), .mem_wren(memWren), .mem_q(memQ),
    .conflict_count(conflictCount), .dma_win_count(dmaWinCount)
  );

  // Zero-limit instance, driven separately.
  logic          zCpuReq, zDmaReq;
  logic          zCpuGnt, zCpuStall, zCpuRvalid, zDmaGnt, zDmaRvalid, zMemWren;
  logic [DW-1:0] zRdata, zMemData;
  logic [AW-1:0] zMemAddress;
  logic [31:0]   zConflict, zDmaWin;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dutZero (
    .clock(clk), .reset(rst),
    .cpu_req(zCpuReq), .cpu_wren(1'b0), .cpu_addr(12'd3), .cpu_wdata(32'd0),
    .cpu_gnt(zCpuGnt), .cpu_stall(zCpuStall), .cpu_rvalid(zCpuRvalid),
    .dma_req(zDmaReq), .dma_wren(1'b0), .dma_addr(12'd9), .dma_wdata(32'd0),
    .dma_gnt(zDmaGnt), .dma_rvalid(zDmaRvalid), .rdata(zRdata),
    .mem_address(zMemAddress), .mem_data(zMemData), .mem_wren(zMemWren), .mem_q(32'h0),
    .conflict_count(zConflict), .dma_win_count(zDmaWin)
  );

  // Synchronous-read data memory behind the arbiter.
  logic [DW-1:0] mem [0:4095];
  always @(posedge clk) begin
    if (memWren) mem[memAddress] <= memData;
    memQ <= mem[memAddress];
  end

  // Reference model state.
  logic [DW-1:0] refMem [0:4095];
  int            streak;        // contended cpu wins since dma last served or went idle
  logic          expCpuRv, expDmaRv, lastCpuGnt, lastDmaGnt;
  logic [DW-1:0] expCpuData, expDmaData;
  logic [31:0]   expConf, expWin;
  logic          obsCpuGnt, obsDmaGnt;
  logic [DW-1:0] obsRdata;
  int            checks = 0;
  int            errors = 0;

  task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clearModel();
    streak   = 0;
    expCpuRv = 1'b0;
    expDmaRv = 1'b0;
    expConf  = '0;
    expWin   = '0;
  endtask

  // One bus cycle: check at the falling edge, advance the model, return at posedge+1.
  task automatic tick();
    logic          eCpu, eDma, eWren;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
    @(negedge clk);
    eDma  = dmaReq && (!cpuReq || streak >= LIMIT);
    eCpu  = cpuReq && !eDma;
    eAddr = '0; eData = '0; eWren = 1'b0;
    if (eCpu) begin
      eAddr = cpuAddr; eData = cpuWdata; eWren = cpuWren;
    end else if (eDma) begin
      eAddr = dmaAddr; eData = dmaWdata; eWren = dmaWren;
    end
    obsCpuGnt = cpuGnt;
    obsDmaGnt = dmaGnt;
    obsRdata  = rdata;
    checkEq("cpu_gnt", 32'(cpuGnt), 32'(eCpu));
    checkEq("dma_gnt", 32'(dmaGnt), 32'(eDma));
    checkEq("cpu_stall", 32'(cpuStall), 32'(cpuReq && !eCpu));
    checkEq("mem_wren", 32'(memWren), 32'(eWren));
    checkEq("mem_address", 32'(memAddress), 32'(eAddr));
    checkEq("mem_data", memData, eData);
    checkEq("cpu_rvalid", 32'(cpuRvalid), 32'(expCpuRv));
    checkEq("dma_rvalid", 32'(dmaRvalid), 32'(expDmaRv));
    if (expCpuRv) checkEq("cpu_rdata", rdata, expCpuData);
    if (expDmaRv) checkEq("dma_rdata", rdata, expDmaData);
`ifdef DMEM_ARB_PERF_EN
    checkEq("conflict_count", conflictCount, expConf);
    checkEq("dma_win_count", dmaWinCount, expWin);
`else
    checkEq("conflict_count", conflictCount, 32'd0);
    checkEq("dma_win_count", dmaWinCount, 32'd0);
`endif
    expCpuRv   = eCpu && !cpuWren;
    expDmaRv   = eDma && !dmaWren;
    expCpuData = refMem[cpuAddr];
    expDmaData = refMem[dmaAddr];
    if (eCpu && cpuWren) refMem[cpuAddr] = cpuWdata;
    if (eDma && dmaWren) refMem[dmaAddr] = dmaWdata;
    if (cpuReq && dmaReq) begin
      expConf = expConf + 32'd1;
      if (eDma) expWin = expWin + 32'd1;
    end
    if (!dmaReq || eDma) streak = 0;
    else if (streak < 255) streak++;
    lastCpuGnt = eCpu;
    lastDmaGnt = eDma;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1: pulse reset within the cycle, check cleared state.
  task automatic doReset();
    rst = 1'b1;
    #1;
    checkEq("rst_cpu_rvalid", 32'(cpuRvalid), 32'd0);
    checkEq("rst_dma_rvalid", 32'(dmaRvalid), 32'd0);
    checkEq("rst_conflict", conflictCount, 32'd0);
    checkEq("rst_dma_win", dmaWinCount, 32'd0);
    #2;
    rst = 1'b0;
    clearModel();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]    = $urandom;
      refMem[i] = mem[i];
    end
    mem[5] = 32'hDEAD; refMem[5] = 32'hDEAD;
    cpuReq = 0; cpuWren = 0; cpuAddr = '0; cpuWdata = '0;
    dmaReq = 0; dmaWren = 0; dmaAddr = '0; dmaWdata = '0;
    zCpuReq = 0; zDmaReq = 0;
    lastCpuGnt = 0; lastDmaGnt = 0;
    clearModel();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkEq("init_cpu_rvalid", 32'(cpuRvalid), 32'd0);
    checkEq("init_conflict", conflictCount, 32'd0);
    rst = 1'b0;

    // Continuous contended reads: C,C,C,C,D repeating.
    cpuReq = 1; cpuWren = 0; cpuAddr = 12'd1;
    dmaReq = 1; dmaWren = 0; dmaAddr = 12'd2;
    for (int i = 0; i < 10; i++) begin
      tick();
      checkEq("t2_dma_slot", 32'(obsDmaGnt), 32'((i % 5) == 4));
    end
`ifdef DMEM_ARB_PERF_EN
    checkEq("t6_conflict", conflictCount, 32'd10);
    checkEq("t6_dma_win", dmaWinCount, 32'd2);
`else
    checkEq("t6_conflict", conflictCount, 32'd0);
    checkEq("t6_dma_win", dmaWinCount, 32'd0);
`endif
    cpuReq = 0; dmaReq = 0;
    tick();

    // Single cpu read of address 5.
    cpuReq = 1; cpuAddr = 12'd5;
    tick();
    checkEq("t1_gnt", 32'(obsCpuGnt), 32'd1);
    cpuReq = 0;
    tick();
    checkEq("t1_rdata", obsRdata, 32'hDEAD);

    // Single dma write to address 7.
    dmaReq = 1; dmaWren = 1; dmaAddr = 12'd7; dmaWdata = 32'h1234;
    tick();
    dmaReq = 0; dmaWren = 0;
    tick();
    checkEq("t3_mem7", mem[7], 32'h1234);

    // Build up starvation, then reset with a cpu read in flight.
    cpuReq = 1; cpuAddr = 12'd4; dmaReq = 1; dmaAddr = 12'd6;
    repeat (3) tick();
    checkEq("t4_rv_inflight", 32'(cpuRvalid), 32'd1);
    doReset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checkEq("t4_dma_slot", 32'(obsDmaGnt), 32'(i == 4));
    end
    cpuReq = 0; dmaReq = 0;
    tick();

    // Zero limit: dma wins every contended cycle.
    zCpuReq = 1; zDmaReq = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkEq("t5_dma_gnt", 32'(zDmaGnt), 32'd1);
      checkEq("t5_cpu_stall", 32'(zCpuStall), 32'd1);
      if (i > 0) checkEq("t5_dma_rvalid", 32'(zDmaRvalid), 32'd1);
    end
    @(posedge clk); #1;
    zDmaReq = 0;
    @(negedge clk);
    checkEq("t5_cpu_gnt", 32'(zCpuGnt), 32'd1);
    checkEq("t5_no_stall", 32'(zCpuStall), 32'd0);
    checkEq("t5_mem_wren", 32'(zMemWren), 32'd0);
    @(posedge clk); #1;
    zCpuReq = 0;

    // Randomized traffic; each side holds its request until granted.
    for (int c = 0; c < 3000; c++) begin
      if (!cpuReq || lastCpuGnt) begin
        cpuReq   = ($urandom % 100) < 75;
        cpuWren  = ($urandom % 3) == 0;
        cpuAddr  = 12'($urandom % 16);
        cpuWdata = $urandom;
      end
      if (!dmaReq || lastDmaGnt) begin
        dmaReq   = ($urandom % 100) < 65;
        dmaWren  = ($urandom % 3) == 0;
        dmaAddr  = 12'($urandom % 16);
        dmaWdata = $urandom;
      end
      if (c == 1500) doReset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
